// File: rtl/fila_requisicoes.sv
// fila_requisicoes: request FIFO and sequencer in front of the 2-way cache.
// Requests are captured on the rising edge of the enter button, buffered, and
// presented to the cache one at a time. Each one is held for HOLD_CYCLES
// cycles after issue so that a miss fill and any writeback can finish. The
// cache hit/writeback outputs are sampled to keep per-run statistics.
module fila_requisicoes #(
    parameter int DEPTH       = 4,
    parameter int HOLD_CYCLES = 4
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     enter,
    input  logic [2:0]               tag_in,
    input  logic [1:0]               indice_in,
    input  logic [2:0]               data_in,
    input  logic                     read_write_in,
    input  logic                     hit_miss,
    input  logic                     writeback,
    output logic [2:0]               tag,
    output logic [1:0]               indice,
    output logic [2:0]               data_out,
    output logic                     read_write,
    output logic                     busy,
    output logic                     empty,
    output logic                     full,
    output logic                     overflow,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     last_hit,
    output logic [7:0]               hits,
    output logic [7:0]               misses,
    output logic [7:0]               writebacks
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam int TW = $clog2(HOLD_CYCLES);
    localparam logic [TW-1:0] TIMER_LOAD = TW'(HOLD_CYCLES - 1);

    typedef struct packed {
        logic [2:0] tag;
        logic [1:0] indice;
        logic [2:0] data;
        logic       rw;
    } req_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ISSUE  = 2'd1,
        HOLD   = 2'd2,
        SAMPLE = 2'd3
    } state_t;

    state_t          state, next_state;
    req_t            mem [DEPTH];
    req_t            entry;
    req_t            head;
    logic [PW-1:0]   wr_ptr, rd_ptr;
    logic            enter_d;
    logic            push, push_ok, pop;
    logic            hold_done;
    logic            hold_first;
    logic [TW-1:0]   timer;
    logic            first_hit;
    logic            wb_seen;

    // Saturating 8-bit increment for the display counters.
    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    assign entry      = '{tag: tag_in, indice: indice_in, data: data_in, rw: read_write_in};
    assign head       = mem[rd_ptr];
    assign push       = enter & ~enter_d;
    // A push into a full queue is dropped even if a pop frees a slot this cycle.
    assign push_ok    = push & ~full;
    assign empty      = (count == '0);
    assign full       = (count == CW'(DEPTH));
    assign busy       = (state != IDLE);
    assign hold_done  = (state == HOLD) && (timer == '0);
    assign hold_first = (state == HOLD) && (timer == TIMER_LOAD);

    // Button edge detector: one push per 0->1 transition of enter.
    always_ff @(posedge clock) begin
        if (reset) enter_d <= 1'b0;
        else       enter_d <= enter;
    end

    // Queue storage; contents need no reset since count gates every read.
    always_ff @(posedge clock) begin
        if (push_ok) mem[wr_ptr] <= entry;
    end

    // Queue pointers and occupancy; overflow is sticky until reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + PW'(1);
            if (pop)     rd_ptr <= rd_ptr + PW'(1);
            unique case ({push_ok, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
            if (push && full) overflow <= 1'b1;
        end
    end

    // Sequencer state register.
    always_ff @(posedge clock) begin
        if (reset) state <= IDLE;
        else       state <= next_state;
    end

    // Sequencer next state; the head is popped only from IDLE.
    always_comb begin
        next_state = state;
        pop        = 1'b0;
        unique case (state)
            IDLE: begin
                if (!empty) begin
                    pop        = 1'b1;
                    next_state = ISSUE;
                end
            end
            ISSUE:   next_state = HOLD;
            HOLD:    if (timer == '0) next_state = SAMPLE;
            SAMPLE:  next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Request outputs to the cache: fields load on pop, read_write drops on
    // entry to SAMPLE so it is a single clean pulse per write.
    always_ff @(posedge clock) begin
        if (reset) begin
            tag        <= '0;
            indice     <= '0;
            data_out   <= '0;
            read_write <= 1'b0;
        end else if (pop) begin
            tag        <= head.tag;
            indice     <= head.indice;
            data_out   <= head.data;
            read_write <= head.rw;
        end else if (hold_done) begin
            read_write <= 1'b0;
        end
    end

    // Hold timer plus hit/writeback capture while the cache works.
    always_ff @(posedge clock) begin
        if (reset) begin
            timer     <= '0;
            first_hit <= 1'b0;
            wb_seen   <= 1'b0;
        end else if (state == ISSUE) begin
            timer   <= TIMER_LOAD;
            wb_seen <= 1'b0;
        end else if (state == HOLD) begin
            timer <= timer - TW'(1);
            if (hold_first) first_hit <= hit_miss;
            if (writeback)  wb_seen   <= 1'b1;
        end
    end

    // Per-run statistics, updated once per completed request in SAMPLE.
    always_ff @(posedge clock) begin
        if (reset) begin
            last_hit   <= 1'b0;
            hits       <= '0;
            misses     <= '0;
            writebacks <= '0;
        end else if (state == SAMPLE) begin
            last_hit <= first_hit;
            if (first_hit) hits   <= sat_inc(hits);
            else           misses <= sat_inc(misses);
            if (wb_seen)   writebacks <= sat_inc(writebacks);
        end
    end

endmodule

// File: tb/tb_fila_requisicoes.sv
// Scoreboard bench for fila_requisicoes: stimulus queues the expected request
// (fields plus the hit/writeback the bench will drive), a negedge monitor
// checks each issue and each completion against it.
module tb_fila_requisicoes;

    logic       clock, reset, enter;
    logic [2:0] tag_in, data_in, tag, data_out;
    logic [1:0] indice_in, indice;
    logic       read_write_in, hit_miss, writeback, read_write;
    logic       busy, empty, full, overflow, last_hit;
    logic [2:0] count;
    logic [7:0] hits, misses, writebacks;

    fila_requisicoes #(.DEPTH(4), .HOLD_CYCLES(4)) dut (
        .clock(clock), .reset(reset), .enter(enter),
        .tag_in(tag_in), .indice_in(indice_in), .data_in(data_in),
        .read_write_in(read_write_in), .hit_miss(hit_miss), .writeback(writeback),
        .tag(tag), .indice(indice), .data_out(data_out), .read_write(read_write),
        .busy(busy), .empty(empty), .full(full), .overflow(overflow), .count(count),
        .last_hit(last_hit), .hits(hits), .misses(misses), .writebacks(writebacks)
    );

    typedef struct {
        logic [2:0] tag;
        logic [1:0] indice;
        logic [2:0] data;
        logic       rw;
        logic       hit;
        logic       wb;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    // fill/overflow schedule: push cycles and whether each is accepted
    int   pc4  [9] = '{0, 2, 4, 8, 10, 12, 14, 16, 22};
    bit   acc4 [9] = '{1, 1, 1, 1, 1, 1, 0, 1, 0};
    int   pc5  [4] = '{0, 2, 4, 6};

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, expv);
        end
    endtask

    task automatic add_exp(input logic [2:0] t, input logic [1:0] i, input logic [2:0] d,
                           input logic rw, input logic h, input logic wb);
        exp_t e;
        e.tag = t; e.indice = i; e.data = d; e.rw = rw; e.hit = h; e.wb = wb;
        exp_q.push_back(e);
    endtask

    task automatic push(input logic [2:0] t, input logic [1:0] i, input logic [2:0] d,
                        input logic rw, input logic h, input logic wb);
        @(posedge clock); #1;
        tag_in = t; indice_in = i; data_in = d; read_write_in = rw; enter = 1'b1;
        add_exp(t, i, d, rw, h, wb);
        @(posedge clock); #1;
        enter = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        @(negedge clock);
        while ((busy || !empty) && n < 300) begin
            n++;
            @(negedge clock);
        end
        if (n >= 300) begin
            checks++; errors++;
            $display("FAIL wait_idle timeout busy=%0b count=%0d", busy, count);
        end
    endtask

    // Monitor: checks issued fields, read_write pulse length and statistics.
    exp_t cur;
    bit   busy_prev = 0, in_flight = 0;
    int   rw_cnt = 0;
    int   m_hits = 0, m_misses = 0, m_wb = 0, m_last = 0;

    always @(negedge clock) begin
        if (reset) begin
            busy_prev = 0; in_flight = 0; rw_cnt = 0;
            m_hits = 0; m_misses = 0; m_wb = 0; m_last = 0;
        end else begin
            if (busy && !busy_prev) begin
                if (exp_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_issue tag=%0d indice=%0d data=%0d", tag, indice, data_out);
                end else begin
                    cur = exp_q.pop_front();
                    in_flight = 1; rw_cnt = 0;
                    chk("issue_fields", {23'd0, tag, indice, data_out, read_write},
                        {23'd0, cur.tag, cur.indice, cur.data, cur.rw});
                end
            end
            if (busy && read_write) rw_cnt++;
            if (!busy && busy_prev && in_flight) begin
                in_flight = 0;
                if (cur.hit) m_hits++; else m_misses++;
                if (cur.wb) m_wb++;
                m_last = cur.hit;
                chk("rw_pulse_len", rw_cnt, cur.rw ? 5 : 0);
                chk("last_hit", last_hit, m_last);
                chk("hits", hits, m_hits);
                chk("misses", misses, m_misses);
                chk("writebacks", writebacks, m_wb);
            end
            busy_prev = busy;
        end
    end

    initial begin
        int n;
        int k;
        reset = 1'b1; enter = 1'b1; hit_miss = 1'b0; writeback = 1'b0;
        tag_in = 3'd1; indice_in = 2'd1; data_in = 3'd2; read_write_in = 1'b0;

        // Enter held high through reset release and for 10 cycles: one push.
        repeat (3) @(posedge clock);
        #1 reset = 1'b0;
        add_exp(3'd1, 2'd1, 3'd2, 1'b0, 1'b0, 1'b0);
        @(negedge clock);
        chk("rst_outputs", {tag, indice, data_out, read_write}, 0);
        chk("rst_flags", {busy, empty, full, overflow, last_hit}, 5'b01000);
        chk("rst_count", count, 0);
        chk("rst_stats", {hits, misses, writebacks}, 0);
        @(negedge clock);
        chk("t1_count_n1", count, 1);
        chk("t1_busy_n1", busy, 0);
        @(negedge clock);
        chk("t1_busy_n2", busy, 1);
        chk("t1_count_n2", count, 0);
        n = 0;
        while (busy && n < 20) begin n++; @(negedge clock); end
        chk("t1_busy_cycles", n, 6);
        chk("t1_count_end", count, 0);
        repeat (2) @(posedge clock);
        #1 enter = 1'b0;
        wait_idle();

        // Write miss then read hit on the same address.
        hit_miss = 1'b0;
        push(3'd5, 2'd2, 3'd3, 1'b1, 1'b0, 1'b0);
        wait_idle();
        hit_miss = 1'b1;
        push(3'd5, 2'd2, 3'd0, 1'b0, 1'b1, 1'b0);
        wait_idle();
        chk("t2_hits", hits, 1);
        chk("t2_misses", misses, 2);
        chk("t2_last_hit", last_hit, 1);

        // Writeback pulse in the third HOLD cycle of a missing request.
        hit_miss = 1'b0;
        push(3'd2, 2'd1, 3'd4, 1'b0, 1'b0, 1'b1);
        n = 0;
        do begin @(negedge clock); n++; end while (!busy && n < 20);
        if (!busy) begin
            checks++; errors++;
            $display("FAIL t3_issue_timeout busy=%0b", busy);
        end
        repeat (2) @(posedge clock);
        @(posedge clock); #1 writeback = 1'b1;
        @(posedge clock); #1 writeback = 1'b0;
        wait_idle();
        chk("t3_writebacks", writebacks, 1);
        chk("t3_misses", misses, 3);
        chk("t3_last_hit", last_hit, 0);

        // Fill past DEPTH while busy, pushes coinciding with pops, pointer wrap.
        hit_miss = 1'b1;
        k = 0;
        for (int c = 0; c < 24; c++) begin
            @(posedge clock); #1;
            enter = 1'b0;
            if (k < 9 && pc4[k] == c) begin
                enter = 1'b1;
                tag_in = 3'(k + 1); indice_in = 2'(k); data_in = 3'(6 - k);
                read_write_in = (k % 2 == 0);
                if (acc4[k]) add_exp(3'(k + 1), 2'(k), 3'(6 - k), (k % 2 == 0), 1'b1, 1'b0);
                k++;
            end
            @(negedge clock);
            case (c)
                9:  chk("t4_push_pop_cnt2", count, 2);
                13: begin chk("t4_full", full, 1); chk("t4_count4", count, 4); chk("t4_no_ovf_yet", overflow, 0); end
                15: begin chk("t4_overflow", overflow, 1); chk("t4_count_after_drop", count, 4); end
                23: begin chk("t4_drop_on_pop_cnt", count, 3); chk("t4_overflow_sticky", overflow, 1); end
                default: ;
            endcase
        end
        #1 enter = 1'b0;
        wait_idle();
        chk("t4_hits", hits, 8);
        chk("t4_empty", empty, 1);

        // Reset in the second HOLD cycle of a write with two entries queued.
        k = 0;
        for (int c = 0; c < 13; c++) begin
            @(posedge clock); #1;
            enter = 1'b0;
            if (k < 4 && pc5[k] == c) begin
                enter = 1'b1;
                tag_in = 3'(k); indice_in = 2'(3 - k); data_in = 3'(k + 4);
                read_write_in = (k % 2 == 1);
                add_exp(3'(k), 2'(3 - k), 3'(k + 4), (k % 2 == 1), 1'b1, 1'b0);
                k++;
            end
            if (c == 11) begin
                reset = 1'b1;
                exp_q.delete();
            end
            @(negedge clock);
            if (c == 11) begin
                chk("t5_pre_count", count, 2);
                chk("t5_pre_rw", read_write, 1);
                chk("t5_pre_busy", busy, 1);
            end
            if (c == 12) begin
                chk("t5_busy", busy, 0);
                chk("t5_count", count, 0);
                chk("t5_rw", read_write, 0);
                chk("t5_stats", {hits, misses, writebacks}, 0);
                chk("t5_flags", {empty, full, overflow, last_hit}, 4'b1000);
            end
        end
        @(posedge clock); #1 reset = 1'b0;

        // Fresh run after reset counts from zero.
        hit_miss = 1'b0;
        push(3'd3, 2'd3, 3'd7, 1'b1, 1'b0, 1'b0);
        wait_idle();
        chk("t6_misses", misses, 1);
        chk("t6_hits", hits, 0);
        chk("t6_scoreboard_drained", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
